// File: rtl/arp_table_if.sv
// Handshake and table-RAM bundle between the ARP table arbiter, its two requesters and the table RAM.
interface arp_table_if #(
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned ENTRY_W   = 89
) ();
    logic                 lu_req_valid;
    logic                 lu_req_ready;
    logic [31:0]          lu_req_ip;
    logic                 lu_rsp_valid;
    logic                 lu_rsp_ready;
    logic                 lu_rsp_hit;
    logic [47:0]          lu_rsp_mac;
    logic [7:0]           lu_rsp_oq;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_BITS-1:0] cpu_idx;
    logic [ENTRY_W-1:0]   cpu_wdata;
    logic                 cpu_ack;
    logic [ENTRY_W-1:0]   cpu_rdata;
    logic [ADDR_BITS-1:0] tbl_addr;
    logic                 tbl_we;
    logic [ENTRY_W-1:0]   tbl_wdata;
    logic [ENTRY_W-1:0]   tbl_rdata;

    modport slave (
        input  lu_req_valid, lu_req_ip, lu_rsp_ready,
        input  cpu_req, cpu_we, cpu_idx, cpu_wdata, tbl_rdata,
        output lu_req_ready, lu_rsp_valid, lu_rsp_hit, lu_rsp_mac, lu_rsp_oq,
        output cpu_ack, cpu_rdata, tbl_addr, tbl_we, tbl_wdata
    );

    modport master (
        output lu_req_valid, lu_req_ip, lu_rsp_ready,
        output cpu_req, cpu_we, cpu_idx, cpu_wdata, tbl_rdata,
        input  lu_req_ready, lu_rsp_valid, lu_rsp_hit, lu_rsp_mac, lu_rsp_oq,
        input  cpu_ack, cpu_rdata, tbl_addr, tbl_we, tbl_wdata
    );
endinterface

// File: rtl/arp_table_arbiter.sv
// Shares the single-port ARP table between linear-scan datapath lookups and CPU entry accesses,
// with lookups preferred until a pending CPU request has been passed over STARVE_LIMIT times.
module arp_table_arbiter #(
    parameter int unsigned TABLE_DEPTH  = 32,
    parameter int unsigned ADDR_BITS    = 5,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ENTRY_W      = 89
) (
    input  logic        AXI_ACLK,
    input  logic        reset,
    arp_table_if.slave  bus,
    output logic [31:0] lookup_count,
    output logic [31:0] miss_count
);
    localparam int unsigned KW     = ADDR_BITS + 1;
    localparam int unsigned SW     = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned IP_W   = 32;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned OQ_W   = 8;
    localparam int unsigned MAC_LO = IP_W;
    localparam int unsigned OQ_LO  = IP_W + MAC_W;

    typedef enum logic [2:0] {IDLE, SCAN, RESP, CPU_ACC, CPU_DONE} state_t;

    state_t            state, state_n;
    logic [KW-1:0]     scan_k, scan_k_n;
    logic [IP_W-1:0]   ip_q, ip_n;
    logic [SW-1:0]     starve_q, starve_n;
    logic              hit_q, hit_n;
    logic [MAC_W-1:0]  mac_q, mac_n;
    logic [OQ_W-1:0]   oq_q, oq_n;
    logic [31:0]       lookup_n, miss_n;
    logic              cpu_wins_c;
    logic              entry_match_c;

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state        <= IDLE;
            scan_k       <= '0;
            ip_q         <= '0;
            starve_q     <= '0;
            hit_q        <= 1'b0;
            mac_q        <= '0;
            oq_q         <= '0;
            lookup_count <= '0;
            miss_count   <= '0;
        end else begin
            state        <= state_n;
            scan_k       <= scan_k_n;
            ip_q         <= ip_n;
            starve_q     <= starve_n;
            hit_q        <= hit_n;
            mac_q        <= mac_n;
            oq_q         <= oq_n;
            lookup_count <= lookup_n;
            miss_count   <= miss_n;
        end
    end

    always_comb begin
        state_n  = state;
        scan_k_n = scan_k;
        ip_n     = ip_q;
        starve_n = starve_q;
        hit_n    = hit_q;
        mac_n    = mac_q;
        oq_n     = oq_q;
        lookup_n = lookup_count;
        miss_n   = miss_count;

        bus.lu_req_ready = 1'b0;
        bus.lu_rsp_valid = 1'b0;
        bus.lu_rsp_hit   = hit_q;
        bus.lu_rsp_mac   = mac_q;
        bus.lu_rsp_oq    = oq_q;
        bus.cpu_ack      = 1'b0;
        bus.cpu_rdata    = '0;
        bus.tbl_addr     = '0;
        bus.tbl_we       = 1'b0;
        bus.tbl_wdata    = '0;

        cpu_wins_c    = bus.cpu_req && (!bus.lu_req_valid || (starve_q >= SW'(STARVE_LIMIT)));
        entry_match_c = bus.tbl_rdata[ENTRY_W-1] && (bus.tbl_rdata[IP_W-1:0] == ip_q);

        case (state)
            IDLE: begin
                bus.lu_req_ready = !reset && !cpu_wins_c;
                if (cpu_wins_c) begin
                    starve_n = '0;
                    state_n  = CPU_ACC;
                end else if (bus.lu_req_valid) begin
                    ip_n     = bus.lu_req_ip;
                    scan_k_n = '0;
                    if (bus.cpu_req && (starve_q < SW'(STARVE_LIMIT)))
                        starve_n = starve_q + SW'(1);
                    state_n  = SCAN;
                end
            end
            // Address k is presented in cycle k; its entry is compared one cycle later.
            SCAN: begin
                if (scan_k < KW'(TABLE_DEPTH))
                    bus.tbl_addr = scan_k[ADDR_BITS-1:0];
                if ((scan_k != '0) && (entry_match_c || (scan_k == KW'(TABLE_DEPTH)))) begin
                    hit_n   = entry_match_c;
                    mac_n   = entry_match_c ? bus.tbl_rdata[MAC_LO +: MAC_W] : '0;
                    oq_n    = entry_match_c ? bus.tbl_rdata[OQ_LO +: OQ_W] : '0;
                    state_n = RESP;
                end else begin
                    scan_k_n = scan_k + KW'(1);
                end
            end
            RESP: begin
                bus.lu_rsp_valid = 1'b1;
                if (bus.lu_rsp_ready) begin
                    if (lookup_count != '1)
                        lookup_n = lookup_count + 32'd1;
                    if (!hit_q && (miss_count != '1))
                        miss_n = miss_count + 32'd1;
                    state_n = IDLE;
                end
            end
            CPU_ACC: begin
                bus.tbl_addr  = bus.cpu_idx;
                bus.tbl_we    = bus.cpu_we;
                bus.tbl_wdata = bus.cpu_wdata;
                state_n       = CPU_DONE;
            end
            CPU_DONE: begin
                bus.cpu_ack   = 1'b1;
                bus.cpu_rdata = bus.cpu_we ? bus.cpu_wdata : bus.tbl_rdata;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arp_table_arbiter.sv
// Scoreboarded bench for arp_table_arbiter with a behavioural 1-cycle-latency table RAM.
module tb_arp_table_arbiter;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned EW    = 89;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lookup_count;
    logic [31:0] miss_count;

    arp_table_if #(.ADDR_BITS(AW), .ENTRY_W(EW)) bus ();

    arp_table_arbiter #(
        .TABLE_DEPTH(DEPTH), .ADDR_BITS(AW), .STARVE_LIMIT(LIMIT), .ENTRY_W(EW)
    ) dut (
        .AXI_ACLK(clk),
        .reset(reset),
        .bus(bus.slave),
        .lookup_count(lookup_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] mem [DEPTH];
    logic          init_mem = 1'b1;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (bus.tbl_we) begin
            mem[bus.tbl_addr] <= bus.tbl_wdata;
        end
        bus.tbl_rdata <= mem[bus.tbl_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        hit;
        logic [47:0] mac;
        logic [7:0]  oq;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [EW-1:0] ref_tbl [DEPTH];

    function automatic logic [EW-1:0] mk(input logic v, input logic [7:0] oq,
                                         input logic [47:0] mac, input logic [31:0] ip);
        return {v, oq, mac, ip};
    endfunction

    // Expected response: lowest valid matching index, latency from accept cycle.
    function automatic exp_t ref_lookup(input logic [31:0] ip, input int acc);
        exp_t e;
        e.hit = 1'b0; e.mac = '0; e.oq = '0; e.cyc = acc + int'(DEPTH) + 2;
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (ref_tbl[j][88] && ref_tbl[j][31:0] == ip) begin
                e.hit = 1'b1; e.mac = ref_tbl[j][79:32]; e.oq = ref_tbl[j][87:80];
                e.cyc = acc + j + 3;
                break;
            end
        end
        return e;
    endfunction

    task automatic lu_send(input logic [31:0] ip, output int acc);
        acc = -1;
        @(negedge clk);
        bus.lu_req_valid = 1'b1;
        bus.lu_req_ip    = ip;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.lu_req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        sb.push_back(ref_lookup(ip, acc));
        @(negedge clk);
        bus.lu_req_valid = 1'b0;
    endtask

    task automatic lu_wait(output int rc, output logic h, output logic [47:0] m, output logic [7:0] o);
        rc = -1; h = 1'b0; m = '0; o = '0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.lu_rsp_valid) begin
                rc = cyc; h = bus.lu_rsp_hit; m = bus.lu_rsp_mac; o = bus.lu_rsp_oq;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] idx, input logic [EW-1:0] wd,
                              output logic [EW-1:0] rd, output int req_cyc, output int ack_cyc);
        rd = '0; ack_cyc = -1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_idx = idx; bus.cpu_wdata = wd;
        req_cyc = cyc;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.cpu_ack) begin
                ack_cyc = cyc; rd = bus.cpu_rdata;
                break;
            end
            @(negedge clk);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.lu_req_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.lu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.lu_req_ready); end
        checks++; if (bus.lu_rsp_valid !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.tbl_we !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got rsp_valid=%b ack=%b we=%b exp all 0", bus.lu_rsp_valid, bus.cpu_ack, bus.tbl_we); end
        checks++; if (lookup_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", lookup_count, miss_count); end
        checks++; if (bus.tbl_addr !== '0 || bus.lu_rsp_mac !== '0 || bus.lu_rsp_oq !== '0) begin
            failures++; $display("FAIL reset_fields got addr=%h mac=%h oq=%h exp 0", bus.tbl_addr, bus.lu_rsp_mac, bus.lu_rsp_oq); end
        bus.lu_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        init_mem = 1'b0;
    endtask

    task automatic test_cpu_write_read();
        logic [EW-1:0] w, rd;
        int rq, ak;
        w = mk(1'b1, 8'h04, 48'h001122334455, 32'h0A000001);
        cpu_access(1'b1, 5'd3, w, rd, rq, ak);
        ref_tbl[3] = w;
        checks++; if (ak !== rq + 2) begin failures++; $display("FAIL cpu_write_ack_cycle got=%0d exp=%0d", ak, rq + 2); end
        checks++; if (rd !== w) begin failures++; $display("FAIL cpu_write_rdata got=%h exp=%h", rd, w); end
        cpu_access(1'b0, 5'd3, '0, rd, rq, ak);
        checks++; if (ak !== rq + 2) begin failures++; $display("FAIL cpu_read_ack_cycle got=%0d exp=%0d", ak, rq + 2); end
        checks++; if (rd !== w) begin failures++; $display("FAIL cpu_readback got=%h exp=%h", rd, w); end
    endtask

    task automatic lookup_and_check(input logic [31:0] ip, input string name);
        int acc, rc;
        logic h; logic [47:0] m; logic [7:0] o;
        exp_t e;
        lu_send(ip, acc);
        lu_wait(rc, h, m, o);
        e = sb.pop_front();
        checks++; if (rc !== e.cyc) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, rc, e.cyc); end
        checks++; if (h !== e.hit || m !== e.mac || o !== e.oq) begin
            failures++; $display("FAIL %s_fields got hit=%b mac=%h oq=%h exp hit=%b mac=%h oq=%h", name, h, m, o, e.hit, e.mac, e.oq); end
    endtask

    task automatic check_counts(input int lc, input int mc, input string name);
        @(negedge clk);
        #1;
        checks++; if (lookup_count !== 32'(lc) || miss_count !== 32'(mc)) begin
            failures++; $display("FAIL %s_counts got=%0d/%0d exp=%0d/%0d", name, lookup_count, miss_count, lc, mc); end
    endtask

    task automatic test_lookup_hit();
        lookup_and_check(32'h0A000001, "hit");
        check_counts(1, 0, "hit");
    endtask

    task automatic test_lookup_miss();
        lookup_and_check(32'h0A0000FF, "miss");
        check_counts(2, 1, "miss");
    endtask

    task automatic test_first_hit();
        logic [EW-1:0] rd;
        int rq, ak;
        logic [EW-1:0] ents [4];
        int idxs [4];
        ents[0] = mk(1'b0, 8'h80, 48'hAAAAAAAAAAAA, 32'h0B000001); idxs[0] = 1;
        ents[1] = mk(1'b1, 8'h01, 48'h0000000000A2, 32'h0B000001); idxs[1] = 2;
        ents[2] = mk(1'b1, 8'h10, 48'h0000000000A5, 32'h0B000001); idxs[2] = 5;
        ents[3] = mk(1'b0, 8'h20, 48'h0000000000A7, 32'h0B000002); idxs[3] = 7;
        for (int i = 0; i < 4; i++) begin
            cpu_access(1'b1, AW'(idxs[i]), ents[i], rd, rq, ak);
            ref_tbl[idxs[i]] = ents[i];
        end
        lookup_and_check(32'h0B000001, "first_hit");
        lookup_and_check(32'h0B000002, "invalid_entry");
        check_counts(4, 2, "first_hit");
    endtask

    task automatic test_starvation();
        int n_acc = 0, n_rsp = 0, ack_cyc = -1, acc_at_ack = -1, rsp4 = -1, acc5 = -1;
        exp_t e;
        @(negedge clk);
        bus.lu_req_valid = 1'b1; bus.lu_req_ip = 32'h0A000001;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_idx = 5'd3; bus.cpu_wdata = '0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (bus.lu_req_valid && bus.lu_req_ready) begin
                n_acc++;
                if (n_acc == 5) acc5 = cyc;
                sb.push_back(ref_lookup(32'h0A000001, cyc));
            end
            if (bus.lu_rsp_valid && bus.lu_rsp_ready) begin
                e = sb.pop_front();
                n_rsp++;
                if (n_rsp == 4) rsp4 = cyc;
                checks++; if (cyc !== e.cyc || bus.lu_rsp_oq !== e.oq || bus.lu_rsp_hit !== e.hit) begin
                    failures++; $display("FAIL b2b_rsp%0d got cyc=%0d oq=%h exp cyc=%0d oq=%h", n_rsp, cyc, bus.lu_rsp_oq, e.cyc, e.oq); end
            end
            if (bus.cpu_ack) begin
                ack_cyc = cyc; acc_at_ack = n_acc;
                checks++; if (bus.cpu_rdata !== ref_tbl[3]) begin
                    failures++; $display("FAIL starve_rdata got=%h exp=%h", bus.cpu_rdata, ref_tbl[3]); end
                bus.cpu_req = 1'b0;
            end
            if (n_rsp == 5) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.lu_req_valid = 1'b0;
        bus.cpu_req = 1'b0;
        checks++; if (acc_at_ack !== int'(LIMIT)) begin failures++; $display("FAIL starve_accepts_before_ack got=%0d exp=%0d", acc_at_ack, LIMIT); end
        checks++; if (ack_cyc !== rsp4 + 3) begin failures++; $display("FAIL starve_ack_cycle got=%0d exp=%0d", ack_cyc, rsp4 + 3); end
        checks++; if (!(ack_cyc >= 0 && acc5 > ack_cyc)) begin failures++; $display("FAIL starve_ack_before_5th got ack=%0d acc5=%0d", ack_cyc, acc5); end
        check_counts(9, 2, "b2b");
    endtask

    task automatic test_backpressure_and_reset();
        int acc, rc, stable_bad = 0, quiet_bad = 0;
        logic h; logic [47:0] m; logic [7:0] o;
        exp_t e;
        bus.lu_rsp_ready = 1'b0;
        lu_send(32'h0A000001, acc);
        lu_wait(rc, h, m, o);
        e = sb.pop_front();
        checks++; if (rc !== e.cyc || o !== e.oq) begin failures++; $display("FAIL bp_first got cyc=%0d oq=%h exp cyc=%0d oq=%h", rc, o, e.cyc, e.oq); end
        bus.lu_req_valid = 1'b1; bus.lu_req_ip = 32'h0B000001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.lu_rsp_valid !== 1'b1 || bus.lu_rsp_hit !== e.hit || bus.lu_rsp_mac !== e.mac ||
                bus.lu_rsp_oq !== e.oq || bus.lu_req_ready !== 1'b0) stable_bad++;
        end
        checks++; if (stable_bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", stable_bad); end
        @(negedge clk);
        bus.lu_rsp_ready = 1'b1;
        bus.lu_req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.lu_rsp_valid !== 1'b0 || lookup_count !== 32'd10) begin
            failures++; $display("FAIL bp_release got valid=%b count=%0d exp valid=0 count=10", bus.lu_rsp_valid, lookup_count); end

        lu_send(32'h0A0000FF, acc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        bus.lu_req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.lu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_ready cycle%0d got=%b exp=0", i, bus.lu_req_ready); end
            @(negedge clk);
        end
        reset = 1'b0;
        bus.lu_req_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.lu_rsp_valid !== 1'b0 || bus.cpu_ack !== 1'b0) quiet_bad++;
            @(negedge clk);
        end
        checks++; if (quiet_bad !== 0) begin failures++; $display("FAIL reset_abort got=%0d response cycles exp=0", quiet_bad); end
        checks++; if (lookup_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++; $display("FAIL reset_mid_counts got=%0d/%0d exp=0/0", lookup_count, miss_count); end
    endtask

    initial begin
        bus.lu_req_valid = 1'b0; bus.lu_req_ip = '0; bus.lu_rsp_ready = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_idx = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_tbl[i] = '0;
        test_reset();
        test_cpu_write_read();
        test_lookup_hit();
        test_lookup_miss();
        test_first_hit();
        test_starvation();
        test_backpressure_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
